multi_lfsr_stream_cipher: RTL and testbench

MULTI_LFSR_STREAM_CIPHER -- requirements
Module: multi_lfsr_stream_cipher

---
 rtl/multi_lfsr_stream_cipher.sv | 148 ++++++++++++++
 tb/tb_multi_lfsr_stream_cipher.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lfsr_stream_cipher.sv
// multi_lfsr_stream_cipher
// Bit-serial stream cipher with CH independent TX/RX channel pairs. Each
// channel owns one TX and one RX Fibonacci LFSR; the keystream bit is the
// LFSR LSB. A serial config chain carries the shared seed, which is loaded
// into every LFSR on the cycle after cfg_en falls.
// Optional feature macro: XCIPHER_LOOPBACK_EN adds a loopback bit at the
// head of the config chain; when set, each RX channel decrypts its own
// TX channel's registered ciphertext instead of rx_e.
module multi_lfsr_stream_cipher #(
    parameter int          W    = 32,
    parameter int          CH   = 2,
    parameter logic [W-1:0] TAPS = W'(32'h0040_0007),
    parameter int          HB_W = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_en,
    input  logic          cfg_i,
    output logic          cfg_o,
    input  logic [CH-1:0] tx_en,
    input  logic [CH-1:0] tx_p,
    output logic [CH-1:0] tx_e,
    input  logic [CH-1:0] rx_en,
    input  logic [CH-1:0] rx_e,
    output logic [CH-1:0] rx_p,
    output logic [2:0]    heartbeat
);

    logic [W-1:0]    r_seed;
    logic            r_cfg_en_d;
    logic [HB_W-1:0] r_hb_cnt;
    logic            w_load;
    logic [W-1:0]    w_load_val;

    // One Fibonacci step: new MSB is the parity of the tapped bits.
    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        return {^(s & TAPS), s[W-1:1]};
    endfunction

    // Load fires on the first cycle with cfg_en low after a shift burst.
    assign w_load     = r_cfg_en_d & ~cfg_en;
    // An all-zero seed would lock the LFSRs up, so it is replaced by 1.
    assign w_load_val = (r_seed == '0) ? W'(1) : r_seed;

`ifdef XCIPHER_LOOPBACK_EN
    logic r_lb;

    // Config chain {lb, seed} shifts MSB-first while cfg_en is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed <= W'(1);
            r_lb   <= 1'b0;
        end else if (cfg_en) begin
            r_seed <= {r_seed[W-2:0], cfg_i};
            r_lb   <= r_seed[W-1];
        end
    end

    assign cfg_o = r_lb;
`else
    // Config chain (seed only) shifts MSB-first while cfg_en is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed <= W'(1);
        end else if (cfg_en) begin
            r_seed <= {r_seed[W-2:0], cfg_i};
        end
    end

    assign cfg_o = r_seed[W-1];
`endif

    // Registered copy of cfg_en for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_en_d <= 1'b0;
        end else begin
            r_cfg_en_d <= cfg_en;
        end
    end

    // Free-running heartbeat counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_cnt <= '0;
        end else begin
            r_hb_cnt <= r_hb_cnt + HB_W'(1);
        end
    end

    assign heartbeat = r_hb_cnt[HB_W-1:HB_W-3];

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [W-1:0] r_tx_lfsr;
        logic [W-1:0] r_rx_lfsr;
        logic         r_tx_e;
        logic         r_rx_p;
        logic         w_tx_step;
        logic         w_rx_step;
        logic         w_rx_in;

        // Load and configuration both take priority over a strobe.
        assign w_tx_step = tx_en[gi] & ~cfg_en & ~w_load;
        assign w_rx_step = rx_en[gi] & ~cfg_en & ~w_load;

`ifdef XCIPHER_LOOPBACK_EN
        assign w_rx_in = r_lb ? r_tx_e : rx_e[gi];
`else
        assign w_rx_in = rx_e[gi];
`endif

        // TX LFSR and ciphertext register; output is 0 when not stepping.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tx_lfsr <= W'(1);
                r_tx_e    <= 1'b0;
            end else if (w_load) begin
                r_tx_lfsr <= w_load_val;
                r_tx_e    <= 1'b0;
            end else if (w_tx_step) begin
                r_tx_lfsr <= lfsr_next(r_tx_lfsr);
                r_tx_e    <= tx_p[gi] ^ r_tx_lfsr[0];
            end else begin
                r_tx_e    <= 1'b0;
            end
        end

        // RX LFSR and plaintext register; mirror image of the TX side.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rx_lfsr <= W'(1);
                r_rx_p    <= 1'b0;
            end else if (w_load) begin
                r_rx_lfsr <= w_load_val;
                r_rx_p    <= 1'b0;
            end else if (w_rx_step) begin
                r_rx_lfsr <= lfsr_next(r_rx_lfsr);
                r_rx_p    <= w_rx_in ^ r_rx_lfsr[0];
            end else begin
                r_rx_p    <= 1'b0;
            end
        end

        assign tx_e[gi] = r_tx_e;
        assign rx_p[gi] = r_rx_p;
    end

endmodule

// File: tb/tb_multi_lfsr_stream_cipher.sv
// Self-checking bench for multi_lfsr_stream_cipher (W=8, TAPS=8'h1D, CH=2).
// The reference model tracks, per LFSR, only the loaded seed and how many
// keystream bits have been consumed; the keystream bit at a position is
// derived from the seed when needed.
module tb_multi_lfsr_stream_cipher;

    localparam int          W    = 8;
    localparam int          CH   = 2;
    localparam int          HB_W = 6;
    localparam logic [W-1:0] TAPS = 8'h1D;
`ifdef XCIPHER_LOOPBACK_EN
    localparam int CHAIN = W + 1;
`else
    localparam int CHAIN = W;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_en;
    logic          cfg_i;
    logic [CH-1:0] tx_en;
    logic [CH-1:0] tx_p;
    logic [CH-1:0] rx_en;
    logic [CH-1:0] rx_e_drv;
    logic          wire_mode;
    logic          cfg_o;
    logic [CH-1:0] tx_e;
    logic [CH-1:0] rx_p;
    logic [CH-1:0] rx_e;
    logic [2:0]    heartbeat;

    // Channel 0 ciphertext can be looped externally into the RX input.
    assign rx_e = wire_mode ? {rx_e_drv[1], tx_e[0]} : rx_e_drv;

    always #5 clk = ~clk;

    multi_lfsr_stream_cipher #(
        .W(W), .CH(CH), .TAPS(TAPS), .HB_W(HB_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_i(cfg_i),
        .cfg_o(cfg_o), .tx_en(tx_en), .tx_p(tx_p), .tx_e(tx_e),
        .rx_en(rx_en), .rx_e(rx_e), .rx_p(rx_p), .heartbeat(heartbeat)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state.
    int            m_cnt;
    logic [CHAIN-1:0] m_chain;
    logic          m_cfgd;
    logic [W-1:0]  m_kseed;
    int            m_tpos [CH];
    int            m_rpos [CH];
    logic [CH-1:0] m_txe;
    logic [CH-1:0] m_rxp;

    // Keystream bit number k produced from a given starting state.
    function automatic logic ks_at(input logic [W-1:0] seed, input int k);
        logic [W-1:0] s;
        s = seed;
        for (int i = 0; i < k; i++) s = {^(s & TAPS), s[W-1:1]};
        return s[0];
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_chain = CHAIN'(1);
        m_cfgd  = 1'b0;
        m_kseed = W'(1);
        for (int c = 0; c < CH; c++) begin
            m_tpos[c] = 0;
            m_rpos[c] = 0;
        end
        m_txe = '0;
        m_rxp = '0;
    endtask

    task automatic model_cycle(input logic ce, input logic ci,
                               input logic [CH-1:0] te, input logic [CH-1:0] tp,
                               input logic [CH-1:0] re, input logic [CH-1:0] rin);
        logic          load;
        logic          lb;
        logic [W-1:0]  seed;
        logic [CH-1:0] n_txe;
        logic [CH-1:0] n_rxp;
        logic          bit_in;
        load = m_cfgd && !ce;
        seed = m_chain[W-1:0];
        lb   = (CHAIN > W) ? m_chain[CHAIN-1] : 1'b0;
        for (int c = 0; c < CH; c++) begin
            n_txe[c] = 1'b0;
            n_rxp[c] = 1'b0;
            if (!ce && !load && te[c]) begin
                n_txe[c] = tp[c] ^ ks_at(m_kseed, m_tpos[c]);
                m_tpos[c]++;
            end
            if (!ce && !load && re[c]) begin
                bit_in   = lb ? m_txe[c] : rin[c];
                n_rxp[c] = bit_in ^ ks_at(m_kseed, m_rpos[c]);
                m_rpos[c]++;
            end
        end
        if (load) begin
            m_kseed = (seed == '0) ? W'(1) : seed;
            for (int c = 0; c < CH; c++) begin
                m_tpos[c] = 0;
                m_rpos[c] = 0;
            end
        end
        if (ce) m_chain = {m_chain[CHAIN-2:0], ci};
        m_cfgd = ce;
        m_txe  = n_txe;
        m_rxp  = n_rxp;
        m_cnt  = (m_cnt + 1) % (1 << HB_W);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".tx_e"}, 32'(tx_e), 32'(m_txe));
        check({tag, ".rx_p"}, 32'(rx_p), 32'(m_rxp));
        check({tag, ".cfg_o"}, 32'(cfg_o), 32'(m_chain[CHAIN-1]));
        check({tag, ".heartbeat"}, 32'(heartbeat), 32'(m_cnt >> (HB_W - 3)));
    endtask

    // One clock: capture inputs, advance the model, compare all outputs.
    task automatic tick(input string tag);
        logic          c_rst, c_ce, c_ci;
        logic [CH-1:0] c_te, c_tp, c_re, c_rin;
        c_rst = rst_n; c_ce = cfg_en; c_ci = cfg_i;
        c_te = tx_en; c_tp = tx_p; c_re = rx_en;
        c_rin = wire_mode ? {rx_e_drv[1], m_txe[0]} : rx_e_drv;
        @(posedge clk);
        #1;
        if (!c_rst) model_reset();
        else model_cycle(c_ce, c_ci, c_te, c_tp, c_re, c_rin);
        check_outputs(tag);
    endtask

    // Shift n bits of v MSB-first with random strobes that must be ignored.
    task automatic shift_bits(input logic [31:0] v, input int n);
        cfg_en = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            cfg_i = v[i];
            tx_en = CH'($urandom); tx_p = CH'($urandom);
            rx_en = CH'($urandom); rx_e_drv = CH'($urandom);
            tick("shift");
            check("shift.tx_e_zero", 32'(tx_e), 32'd0);
            check("shift.rx_p_zero", 32'(rx_p), 32'd0);
        end
        cfg_en = 1'b0; cfg_i = 1'b0;
        tx_en = '0; tx_p = '0; rx_en = '0; rx_e_drv = '0;
    endtask

    logic [4:0]  exp5;
    logic [7:0]  pat;
    logic        hist [0:63];

    initial begin
        rst_n = 1'b0; cfg_en = 1'b0; cfg_i = 1'b0; wire_mode = 1'b0;
        tx_en = '0; tx_p = '0; rx_en = '0; rx_e_drv = '0;
        model_reset();
        exp5 = 5'b10000;
        pat  = 8'hA5;

        // Reset state.
        tick("reset");
        tick("reset");
        check("reset.heartbeat", 32'(heartbeat), 32'd0);
        rst_n = 1'b1;
        tick("idle");

        // Seed 0x01: first five strobed bits are 1,0,0,0,0.
        shift_bits(32'h01, CHAIN);
        tx_en = 2'b01; tx_p = 2'b00;
        tick("load01");
        check("load01.strobe_ignored", 32'(tx_e[0]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick("seed01");
            check("seed01.ks", 32'(tx_e[0]), 32'(exp5[4-k]));
        end
        tx_en = '0;

        // Seed 0x00 behaves exactly like 0x01.
        shift_bits(32'h00, CHAIN);
        tx_en = 2'b01; tx_p = 2'b00;
        tick("load00");
        for (int k = 0; k < 5; k++) begin
            tick("seed00");
            check("seed00.ks", 32'(tx_e[0]), 32'(exp5[4-k]));
        end
        // Run long enough to go around a large part of the sequence.
        for (int k = 0; k < 40; k++) begin
            tx_p = CH'($urandom);
            tick("seed00.run");
        end
        tx_en = '0;

        // External loopback: tx_e[0] wired into rx_e[0], both seeded 0x01.
        wire_mode = 1'b1;
        shift_bits(32'h01, CHAIN);
        tick("load_wire");
        for (int k = 0; k < 32; k++) begin
            tx_en = 2'b01; rx_en = (k > 0) ? 2'b01 : 2'b00;
            tx_p[0] = 1'($urandom);
            hist[k] = tx_p[0];
            tick("wire");
            if (k > 0) check("wire.rx_p0", 32'(rx_p[0]), 32'(hist[k-1]));
        end
        tx_en = '0; rx_en = 2'b01;
        tick("wire.tail");
        check("wire.rx_p0_last", 32'(rx_p[0]), 32'(hist[31]));
        rx_en = '0; wire_mode = 1'b0;

        // Config chain: cfg_o replays 0xA5 MSB-first.
        shift_bits(32'(pat) << (CHAIN - W), CHAIN);
        cfg_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("cfg_o.replay", 32'(cfg_o), 32'(pat[7-k]));
            cfg_i = 1'b0;
            tick("replay");
            check("replay.tx_e_zero", 32'(tx_e), 32'd0);
            check("replay.rx_p_zero", 32'(rx_p), 32'd0);
        end
        cfg_en = 1'b0;
        tick("replay.load");

`ifdef XCIPHER_LOOPBACK_EN
        // Internal loopback on channel 1: rx_e is ignored.
        shift_bits(32'h101, CHAIN);
        tick("load_lb");
        for (int k = 0; k < 24; k++) begin
            tx_en = 2'b10; rx_en = (k > 0) ? 2'b10 : 2'b00;
            tx_p[1] = 1'($urandom); rx_e_drv = CH'($urandom);
            hist[k] = tx_p[1];
            tick("lb");
            if (k > 0) check("lb.rx_p1", 32'(rx_p[1]), 32'(hist[k-1]));
        end
        tx_en = '0; rx_en = '0;
        shift_bits(32'h001, CHAIN);
        tick("load_lb_off");
`endif

        // Randomized traffic with occasional config bursts.
        for (int k = 0; k < 400; k++) begin
            tx_en = CH'($urandom); tx_p = CH'($urandom);
            rx_en = CH'($urandom); rx_e_drv = CH'($urandom);
            if (cfg_en) cfg_en = ($urandom_range(0, 7) != 0);
            else        cfg_en = ($urandom_range(0, 15) == 0);
            cfg_i = 1'($urandom);
            tick("random");
        end
        cfg_en = 1'b0;
        tick("random.settle");

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 10; k++) begin
            tx_en = 2'b11; rx_en = 2'b11;
            tx_p = CH'($urandom); rx_e_drv = CH'($urandom);
            tick("prerst");
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        check("async_rst.heartbeat", 32'(heartbeat), 32'd0);
        tick("rst_hold");
        rst_n = 1'b1; tx_en = 2'b01; tx_p = 2'b00; rx_en = '0;
        tick("post_rst");
        check("post_rst.ks0", 32'(tx_e[0]), 32'd1);
        tick("post_rst");
        check("post_rst.ks1", 32'(tx_e[0]), 32'd0);

        // Asynchronous reset mid-shift: no load after release.
        tx_en = '0; cfg_en = 1'b1; cfg_i = 1'b1;
        for (int k = 0; k < 3; k++) tick("midshift");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("shift_rst");
        cfg_en = 1'b0; cfg_i = 1'b0;
        tick("shift_rst_hold");
        rst_n = 1'b1; tx_en = 2'b01; tx_p = 2'b00;
        tick("post_shift_rst");
        check("post_shift_rst.ks0", 32'(tx_e[0]), 32'd1);
        tx_en = '0;
        tick("end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
